// File: rtl/risc_controller_if.sv
// Handshake and datapath-control bundle between a sequencer (master) and
// the risc_controller (slave).
`timescale 1ns/1ps

interface risc_controller_if;
    logic        start;
    logic [15:0] instr;
    logic        done;
    logic        err;
    logic        busy;
    logic        loada;
    logic        loadb;
    logic        asel;
    logic        bsel;
    logic        loadc;
    logic        loads;
    logic        write;
    logic        vsel;
    logic [2:0]  readnum;
    logic [2:0]  writenum;
    logic [1:0]  shift;
    logic [1:0]  ALUop;
    logic [15:0] sximm5;
    logic [15:0] sximm8;

    modport master (
        output start, instr,
        input  done, err, busy, loada, loadb, asel, bsel, loadc, loads,
               write, vsel, readnum, writenum, shift, ALUop, sximm5, sximm8
    );

    modport slave (
        input  start, instr,
        output done, err, busy, loada, loadb, asel, bsel, loadc, loads,
               write, vsel, readnum, writenum, shift, ALUop, sximm5, sximm8
    );
endinterface

// File: rtl/risc_controller.sv
// Multi-cycle instruction controller: latches an instruction, then walks a
// Moore FSM that drives register-file, shifter and ALU controls from ir.
`timescale 1ns/1ps

module risc_controller (
    input  logic                clk,
    input  logic                resetn,
    risc_controller_if.slave    bus
);

    typedef enum logic [2:0] {
        S_WAIT, S_DEC, S_GETA, S_GETB, S_ALU, S_WREG, S_WIMM, S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic        err_q, err_d;

    logic [4:0]  opc;
    logic        is_movi, is_movr, is_add, is_cmp, is_and, is_mvn;

    assign opc     = ir_q[15:11];
    assign is_movi = (opc == 5'b11010);
    assign is_movr = (opc == 5'b11000);
    assign is_add  = (opc == 5'b10100);
    assign is_cmp  = (opc == 5'b10101);
    assign is_and  = (opc == 5'b10110);
    assign is_mvn  = (opc == 5'b10111);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; the asynchronous clear aborts an instruction instantly.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_WAIT;
            ir_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            err_q   <= err_d;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        err_d        = err_q;
        bus.done     = 1'b0;
        bus.loada    = 1'b0;
        bus.loadb    = 1'b0;
        bus.asel     = 1'b0;
        bus.bsel     = 1'b0;
        bus.loadc    = 1'b0;
        bus.loads    = 1'b0;
        bus.write    = 1'b0;
        bus.vsel     = 1'b0;
        bus.readnum  = 3'd0;
        bus.writenum = 3'd0;
        bus.shift    = 2'b00;
        bus.ALUop    = 2'b00;

        unique case (state_q)
            S_WAIT: begin
                if (bus.start) begin
                    ir_d    = bus.instr;
                    err_d   = 1'b0;
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                if (is_movi) begin
                    state_d = S_WIMM;
                end else if (is_movr || is_mvn) begin
                    state_d = S_GETB;
                end else if (is_add || is_cmp || is_and) begin
                    state_d = S_GETA;
                end else begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end
            end
            S_GETA: begin
                bus.loada   = 1'b1;
                bus.readnum = ir_q[10:8];
                state_d     = S_GETB;
            end
            S_GETB: begin
                bus.loadb   = 1'b1;
                bus.readnum = ir_q[2:0];
                state_d     = S_ALU;
            end
            S_ALU: begin
                bus.shift = ir_q[4:3];
                bus.asel  = is_movr || is_mvn;
                // MOV reg passes the shifted B operand straight through the ALU.
                bus.ALUop = is_movr ? 2'b00 : ir_q[12:11];
                bus.loads = is_cmp;
                bus.loadc = !is_cmp;
                state_d   = is_cmp ? S_DONE : S_WREG;
            end
            S_WREG: begin
                bus.write    = 1'b1;
                bus.writenum = ir_q[7:5];
                state_d      = S_DONE;
            end
            S_WIMM: begin
                bus.write    = 1'b1;
                bus.vsel     = 1'b1;
                bus.writenum = ir_q[10:8];
                state_d      = S_DONE;
            end
            S_DONE: begin
                bus.done = 1'b1;
                state_d  = S_WAIT;
            end
            default: state_d = S_WAIT;
        endcase
    end

    assign bus.busy   = (state_q != S_WAIT);
    assign bus.err    = err_q;
    assign bus.sximm5 = {{11{ir_q[4]}}, ir_q[4:0]};
    assign bus.sximm8 = {{8{ir_q[7]}}, ir_q[7:0]};

endmodule

// File: tb/tb_risc_controller.sv
// Scoreboard bench for risc_controller: expected control vectors are queued
// per instruction and compared by a monitor on every busy cycle.
`timescale 1ns/1ps

module tb_risc_controller;

    logic clk = 1'b0;
    logic resetn = 1'b0;

    risc_controller_if bus ();

    risc_controller dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        done;
        logic        err;
        logic        busy;
        logic        loada;
        logic        loadb;
        logic        asel;
        logic        bsel;
        logic        loadc;
        logic        loads;
        logic        write;
        logic        vsel;
        logic [2:0]  readnum;
        logic [2:0]  writenum;
        logic [1:0]  shift;
        logic [1:0]  alu_op;
        logic [15:0] sximm5;
        logic [15:0] sximm8;
    } ctl_t;

    ctl_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic ctl_t sample();
        ctl_t s;
        s.done     = bus.done;
        s.err      = bus.err;
        s.busy     = bus.busy;
        s.loada    = bus.loada;
        s.loadb    = bus.loadb;
        s.asel     = bus.asel;
        s.bsel     = bus.bsel;
        s.loadc    = bus.loadc;
        s.loads    = bus.loads;
        s.write    = bus.write;
        s.vsel     = bus.vsel;
        s.readnum  = bus.readnum;
        s.writenum = bus.writenum;
        s.shift    = bus.shift;
        s.alu_op   = bus.ALUop;
        s.sximm5   = bus.sximm5;
        s.sximm8   = bus.sximm8;
        return s;
    endfunction

    function automatic ctl_t base(input logic [15:0] s5, input logic [15:0] s8);
        ctl_t b;
        b        = '0;
        b.busy   = 1'b1;
        b.sximm5 = s5;
        b.sximm8 = s8;
        return b;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every busy cycle must match the next queued expectation.
    always @(negedge clk) begin : monitor
        ctl_t e;
        if (bus.busy === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_busy_cycle: got %h expected no busy cycle at %0t",
                         sample(), $time);
            end else begin
                e = exp_q.pop_front();
                check("ctl_vector", 64'(sample()), 64'(e));
            end
        end
    end

    // Start one instruction and measure start-edge-to-done latency.
    task automatic issue(input logic [15:0] ins, input int lat, input bit poke, input bit now);
        int n;
        if (!now) begin
            @(posedge clk);
            #1;
        end
        check("idle_before_start", 64'(bus.busy), 64'(0));
        bus.start = 1'b1;
        bus.instr = ins;
        @(posedge clk);
        #1;
        if (poke) begin
            bus.instr = 16'hA148;
        end else begin
            bus.start = 1'b0;
            bus.instr = ~ins;
        end
        n = 0;
        do begin
            n++;
            @(negedge clk);
        end while (bus.done !== 1'b1 && n < 20);
        check("latency", 64'(n), 64'(lat));
        bus.start = 1'b0;
    endtask

    task automatic push_movi(input logic [15:0] s5, input logic [15:0] s8, input logic [2:0] rn);
        ctl_t v;
        v = base(s5, s8);
        exp_q.push_back(v);
        v.write = 1'b1; v.vsel = 1'b1; v.writenum = rn;
        exp_q.push_back(v);
        v = base(s5, s8); v.done = 1'b1;
        exp_q.push_back(v);
    endtask

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : stim
        ctl_t v;
        bus.start = 1'b1;
        bus.instr = 16'hA148;
        resetn    = 1'b0;
        #7;
        check("reset_outputs", 64'(sample()), 64'(0));
        #5;
        bus.start = 1'b0;
        resetn    = 1'b1;

        // MOV R0,#7
        push_movi(16'h0007, 16'h0007, 3'd0);
        issue(16'hD007, 3, 1'b0, 1'b0);

        // MOV R3,#-1
        push_movi(16'hFFFF, 16'hFFFF, 3'd3);
        issue(16'hD3FF, 3, 1'b0, 1'b0);

        // ADD R2,R1,R0 LSL1
        v = base(16'h0008, 16'h0048); exp_q.push_back(v);
        v = base(16'h0008, 16'h0048); v.loada = 1'b1; v.readnum = 3'd1; exp_q.push_back(v);
        v = base(16'h0008, 16'h0048); v.loadb = 1'b1; v.readnum = 3'd0; exp_q.push_back(v);
        v = base(16'h0008, 16'h0048); v.loadc = 1'b1; v.shift = 2'b01; v.alu_op = 2'b00; exp_q.push_back(v);
        v = base(16'h0008, 16'h0048); v.write = 1'b1; v.writenum = 3'd2; exp_q.push_back(v);
        v = base(16'h0008, 16'h0048); v.done = 1'b1; exp_q.push_back(v);
        issue(16'hA148, 6, 1'b0, 1'b0);

        // start held through DONE is ignored, then accepted in WAIT: CMP R1,R0
        bus.start = 1'b1;
        bus.instr = 16'hA900;
        v = base(16'h0000, 16'h0000); exp_q.push_back(v);
        v = base(16'h0000, 16'h0000); v.loada = 1'b1; v.readnum = 3'd1; exp_q.push_back(v);
        v = base(16'h0000, 16'h0000); v.loadb = 1'b1; v.readnum = 3'd0; exp_q.push_back(v);
        v = base(16'h0000, 16'h0000); v.loads = 1'b1; v.alu_op = 2'b01; exp_q.push_back(v);
        v = base(16'h0000, 16'h0000); v.done = 1'b1; exp_q.push_back(v);
        issue(16'hA900, 5, 1'b0, 1'b0);

        // MVN R7,R1
        v = base(16'h0001, 16'hFFE1); exp_q.push_back(v);
        v = base(16'h0001, 16'hFFE1); v.loadb = 1'b1; v.readnum = 3'd1; exp_q.push_back(v);
        v = base(16'h0001, 16'hFFE1); v.asel = 1'b1; v.loadc = 1'b1; v.alu_op = 2'b11; exp_q.push_back(v);
        v = base(16'h0001, 16'hFFE1); v.write = 1'b1; v.writenum = 3'd7; exp_q.push_back(v);
        v = base(16'h0001, 16'hFFE1); v.done = 1'b1; exp_q.push_back(v);
        issue(16'hB8E1, 5, 1'b0, 1'b0);

        // MOV R7,R2 LSR
        v = base(16'hFFF2, 16'hFFF2); exp_q.push_back(v);
        v = base(16'hFFF2, 16'hFFF2); v.loadb = 1'b1; v.readnum = 3'd2; exp_q.push_back(v);
        v = base(16'hFFF2, 16'hFFF2); v.asel = 1'b1; v.loadc = 1'b1; v.shift = 2'b10; exp_q.push_back(v);
        v = base(16'hFFF2, 16'hFFF2); v.write = 1'b1; v.writenum = 3'd7; exp_q.push_back(v);
        v = base(16'hFFF2, 16'hFFF2); v.done = 1'b1; exp_q.push_back(v);
        issue(16'hC0F2, 5, 1'b0, 1'b0);

        // Illegal opcode: err sets on DONE and holds while idle
        v = base(16'h0000, 16'h0000); exp_q.push_back(v);
        v = base(16'h0000, 16'h0000); v.done = 1'b1; v.err = 1'b1; exp_q.push_back(v);
        issue(16'hE000, 2, 1'b0, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("err_hold", 64'(bus.err), 64'(1));
        end
        push_movi(16'h0007, 16'h0007, 3'd0);
        issue(16'hD007, 3, 1'b0, 1'b0);

        // Async reset during GETB of an ADD
        v = base(16'h0008, 16'h0048); exp_q.push_back(v);
        v = base(16'h0008, 16'h0048); v.loada = 1'b1; v.readnum = 3'd1; exp_q.push_back(v);
        v = base(16'h0008, 16'h0048); v.loadb = 1'b1; v.readnum = 3'd0; exp_q.push_back(v);
        @(posedge clk);
        #1;
        bus.start = 1'b1;
        bus.instr = 16'hA148;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("async_reset_outputs", 64'(sample()), 64'(0));
        repeat (2) begin
            @(negedge clk);
            check("no_write_in_reset", 64'(bus.write), 64'(0));
        end
        check("aborted_queue_drained", 64'(exp_q.size()), 64'(0));
        @(posedge clk);
        #3;
        resetn = 1'b1;

        // First edge after release accepts; busy-time starts are ignored
        push_movi(16'h0007, 16'h0007, 3'd0);
        issue(16'hD007, 3, 1'b1, 1'b1);

        @(posedge clk);
        #1;
        check("final_idle", 64'(bus.busy), 64'(0));
        check("queue_drained", 64'(exp_q.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/risc_controller.md
RISC_CONTROLLER -- requirements
Module: risc_controller

Interface
REQ-001 The block SHALL have no parameters; the data width is fixed at 16 and the register index width at 3.
REQ-002 clk  in  1  Single clock; all state updates occur on the rising edge.
REQ-003 resetn  in  1  Asynchronous, active-low reset.
REQ-004 start  in  1  Request to execute instr; sampled only in WAIT.
REQ-005 instr  in  16  Instruction: [15:13] opcode, [12:11] op, [10:8] Rn, [7:5] Rd, [4:3] shift, [2:0] Rm, [7:0] imm8, [4:0] imm5.
REQ-006 done  out  1  One-cycle pulse on completion.
REQ-007 err  out  1  Last instruction was illegal; held until the next accepted start.
REQ-008 busy  out  1  High in every state except WAIT.
REQ-009 loada, loadb, asel, bsel, loadc, loads, write, vsel  out  1 each  Datapath controls; vsel=0 selects C and vsel=1 selects sximm8.
REQ-010 readnum, writenum  out  3 each  Datapath register read and write indices.
REQ-011 shift, ALUop  out  2 each  Datapath shifter and ALU controls.
REQ-012 sximm5, sximm8  out  16 each  Sign-extended ir[4:0] and ir[7:0].

Function
REQ-013 On start=1 in WAIT, the block SHALL latch instr into the internal register ir and enter DEC on the same edge.
REQ-014 States SHALL be WAIT, DEC, GETA, GETB, ALU, WREG, WIMM and DONE.
REQ-015 All control outputs SHALL be Moore outputs decoded from state and ir only, never from the live instr input.
REQ-016 Transitions out of DEC SHALL be decided by ir[15:11]:
- 11010 (MOV imm): WIMM
- 11000 (MOV reg): GETB
- 10100 (ADD), 10101 (CMP), 10110 (AND): GETA
- 10111 (MVN): GETB
- any other value: DONE with err set
REQ-017 Other transitions SHALL be unconditional:
- GETA to GETB
- GETB to ALU
- ALU to DONE for CMP, otherwise ALU to WREG
- WREG to DONE
- WIMM to DONE
- DONE to WAIT
REQ-018 In GETA the outputs SHALL be loada=1 and readnum=ir[10:8].
REQ-019 In GETB the outputs SHALL be loadb=1 and readnum=ir[2:0].
REQ-020 In ALU the outputs SHALL be shift=ir[4:3] and bsel=0, with:
- asel=1 for MOV reg and MVN, otherwise asel=0
- ALUop=00 for MOV reg, otherwise ALUop=ir[12:11]
- loads=1 and loadc=0 for CMP, otherwise loadc=1 and loads=0
REQ-021 In WREG the outputs SHALL be write=1, vsel=0 and writenum=ir[7:5].
REQ-022 In WIMM the outputs SHALL be write=1, vsel=1 and writenum=ir[10:8].
REQ-023 In DONE, done SHALL be 1 for exactly one cycle.
REQ-024 Any output not driven in a state SHALL be 0, except sximm5 and sximm8, which always reflect ir.
REQ-025 Latency from the start edge to the done cycle, counted in cycles, SHALL be:
- MOV imm: 3
- MOV reg and MVN: 5
- ADD and AND: 6
- CMP: 5
- illegal: 2
REQ-026 start SHALL be ignored while busy=1, and ir SHALL NOT change while busy=1.
REQ-027 start=1 during DONE SHALL be ignored, and start=1 in the following WAIT cycle SHALL be accepted, so back-to-back instructions have one idle cycle between them.
REQ-028 err SHALL be cleared on the edge that accepts a start and set on the DEC-to-DONE transition for an illegal opcode.
REQ-029 Only one write pulse SHALL occur per instruction, and none for CMP or an illegal opcode.

Reset
REQ-030 While resetn=0, the block SHALL force state=WAIT and ir=0x0000, and all outputs SHALL be 0, including sximm5, sximm8, err and busy.
REQ-031 Reset asserted mid-instruction SHALL abort the instruction immediately without waiting for a clock edge, and SHALL suppress any pending write.
REQ-032 After resetn rises, the first start SHALL be acceptable on the first rising edge.

Verification
REQ-033 The bench SHALL drive instr=0xD007 (MOV R0,#7) with start and SHALL check:
- the following states are DEC, WIMM, DONE
- in WIMM: write=1, vsel=1, writenum=0, sximm8=0x0007
- done pulses in the third cycle after the start edge
REQ-034 The bench SHALL drive instr=0xD3FF (MOV R3,#-1) and SHALL check:
- sximm8=0xFFFF and writenum=3 in WIMM
REQ-035 The bench SHALL drive instr=0xA148 (ADD R2,R1,R0 LSL1) and SHALL check:
- GETA: readnum=1, loada=1
- GETB: readnum=0, loadb=1
- ALU: loadc=1, ALUop=00, shift=01, asel=0
- WREG: write=1, writenum=2, vsel=0
- done in the sixth cycle
REQ-036 The bench SHALL drive instr=0xA900 (CMP R1,R0) and SHALL check:
- in ALU: loads=1, loadc=0, ALUop=01
- write stays 0 for the whole instruction
- done in the fifth cycle
REQ-037 The bench SHALL drive instr=0xE000 (illegal) and SHALL check:
- done in the second cycle with err=1
- err holds until the next accepted start, then clears
REQ-038 The bench SHALL start 0xA148, assert resetn=0 during GETB, and SHALL check:
- all outputs go to 0 asynchronously
- no write occurs
- after release, 0xD007 completes normally
- start pulses issued while busy=1 are ignored and ir is unchanged
